// File: rtl/inst_constraint_pkg.sv
// Shared encodings for the QED instruction-legality checker: RV32I opcode and funct
// constants, the canonical NOP word, and the class codes reported by inst_constraint.
package inst_constraint_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_SR      = 3'b101;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_NOP     = 3'd1,
      CLS_ALU_R   = 3'd2,
      CLS_ALU_I   = 3'd3,
      CLS_LOAD    = 3'd4,
      CLS_STORE   = 3'd5,
      CLS_MULDIV  = 3'd6
   } inst_class_e;

endpackage

// File: rtl/inst_decode.sv
// Combinational field extraction and opcode/funct classification. Register and address
// range checks are left to the top level. Macro INST_CONSTRAINT_MULDIV_EN adds M-extension ops.
module inst_decode
   import inst_constraint_pkg::*;
(
   input  logic [31:0]  instruction,
   output inst_class_e  cand_class,
   output logic [4:0]   rd,
   output logic [4:0]   rs1,
   output logic [4:0]   rs2,
   output logic [11:0]  mem_imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instruction[6:0];
   assign rd     = instruction[11:7];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign funct7 = instruction[31:25];

   // Stores split their offset around rd; loads carry it contiguously in [31:20].
   assign mem_imm = (opcode == OP_STORE) ? {instruction[31:25], instruction[11:7]}
                                         : instruction[31:20];

   always_comb begin
      cand_class = CLS_ILLEGAL;
      if (instruction == NOP_INSTR) begin
         cand_class = CLS_NOP;
      end else begin
         case (opcode)
            OP_R: begin
               if (funct7 == F7_BASE)
                  cand_class = CLS_ALU_R;
               else if (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR))
                  cand_class = CLS_ALU_R;
`ifdef INST_CONSTRAINT_MULDIV_EN
               else if (funct7 == F7_MULDIV)
                  cand_class = CLS_MULDIV;
`endif
            end
            OP_I: begin
               if (funct3 == F3_SLL) begin
                  if (funct7 == F7_BASE)
                     cand_class = CLS_ALU_I;
               end else if (funct3 == F3_SR) begin
                  if (funct7 == F7_BASE || funct7 == F7_ALT)
                     cand_class = CLS_ALU_I;
               end else begin
                  cand_class = CLS_ALU_I;
               end
            end
            OP_LOAD: begin
               if (funct3 == F3_WORD)
                  cand_class = CLS_LOAD;
            end
            OP_STORE: begin
               if (funct3 == F3_WORD)
                  cand_class = CLS_STORE;
            end
            default: cand_class = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/inst_constraint.sv
// QED instruction-legality checker: combinational verdict/class plus sticky violation
// bookkeeping. Optional MULDIV acceptance is enabled by macro INST_CONSTRAINT_MULDIV_EN.
module inst_constraint
   import inst_constraint_pkg::*;
#(
   parameter int NUM_ORIG_REGS = 16,
   parameter int MEM_WORDS     = 16,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   input  logic [31:0]      instruction,
   output logic             inst_allowed,
   output logic [2:0]       inst_class,
   output logic             violation,
   output logic [CNT_W-1:0] violation_count,
   output logic [31:0]      first_bad_instr
);

   localparam logic [5:0]  NREG   = 6'(NUM_ORIG_REGS);
   localparam logic [10:0] MWORDS = 11'(MEM_WORDS);

   inst_class_e cand_class;
   inst_class_e cls;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [11:0] mem_imm;
   logic        rd_ok;
   logic        rs1_ok;
   logic        rs2_ok;
   logic        mem_ok;

   inst_decode u_decode (
      .instruction (instruction),
      .cand_class  (cand_class),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .mem_imm     (mem_imm)
   );

   // x0 as destination is only tolerated in the canonical NOP, which bypasses these checks.
   assign rd_ok  = (rd != 5'd0) && ({1'b0, rd} < NREG);
   assign rs1_ok = {1'b0, rs1} < NREG;
   assign rs2_ok = {1'b0, rs2} < NREG;
   assign mem_ok = (rs1 == 5'd0) && (mem_imm[1:0] == 2'b00) && !mem_imm[11]
                   && ({1'b0, mem_imm[11:2]} < MWORDS);

   always_comb begin
      cls = CLS_ILLEGAL;
      case (cand_class)
         CLS_NOP:               cls = CLS_NOP;
         CLS_ALU_R, CLS_MULDIV: if (rd_ok && rs1_ok && rs2_ok) cls = cand_class;
         CLS_ALU_I:             if (rd_ok && rs1_ok) cls = CLS_ALU_I;
         CLS_LOAD:              if (rd_ok && mem_ok) cls = CLS_LOAD;
         CLS_STORE:             if (rs2_ok && mem_ok) cls = CLS_STORE;
         default:               cls = CLS_ILLEGAL;
      endcase
   end

   assign inst_class   = cls;
   assign inst_allowed = (cls != CLS_ILLEGAL);

   always_ff @(posedge clk) begin
      if (rst) begin
         violation       <= 1'b0;
         violation_count <= '0;
         first_bad_instr <= '0;
      end else if (instr_valid && !inst_allowed) begin
         violation <= 1'b1;
         if (violation_count != {CNT_W{1'b1}})
            violation_count <= violation_count + 1'b1;
         if (!violation)
            first_bad_instr <= instruction;
      end
   end

endmodule

// File: tb/tb_inst_constraint.sv
// Scoreboard bench for inst_constraint: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_inst_constraint;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        inst_allowed;
   logic [2:0]  inst_class;
   logic        violation;
   logic [15:0] violation_count;
   logic [31:0] first_bad_instr;

   typedef struct {
      logic [31:0] instr;
      logic        allowed;
      logic [2:0]  cls;
      logic        viol;
      logic [15:0] cnt;
      logic [31:0] first;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;

   logic        m_viol;
   logic [15:0] m_cnt;
   logic [31:0] m_first;

`ifdef INST_CONSTRAINT_MULDIV_EN
   localparam logic       MUL_OK  = 1'b1;
   localparam logic [2:0] MUL_CLS = 3'd6;
`else
   localparam logic       MUL_OK  = 1'b0;
   localparam logic [2:0] MUL_CLS = 3'd0;
`endif

   inst_constraint dut (
      .clk             (clk),
      .rst             (rst),
      .instr_valid     (instr_valid),
      .instruction     (instruction),
      .inst_allowed    (inst_allowed),
      .inst_class      (inst_class),
      .violation       (violation),
      .violation_count (violation_count),
      .first_bad_instr (first_bad_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle; the expected registered state is the model state before this edge.
   task automatic step(input logic [31:0] ins, input logic v, input logic r,
                       input logic exp_ok, input logic [2:0] exp_cls);
      exp_t e;
      @(posedge clk);
      #1;
      instruction = ins;
      instr_valid = v;
      rst         = r;
      e.instr   = ins;
      e.allowed = exp_ok;
      e.cls     = exp_cls;
      e.viol    = m_viol;
      e.cnt     = m_cnt;
      e.first   = m_first;
      sb_q.push_back(e);
      if (r) begin
         m_viol  = 1'b0;
         m_cnt   = 16'h0;
         m_first = 32'h0;
      end else if (v && !exp_ok) begin
         if (!m_viol) m_first = ins;
         m_viol = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (inst_allowed !== e.allowed) begin
               errors++;
               $display("FAIL allowed instr=%h got=%b exp=%b", e.instr, inst_allowed, e.allowed);
            end
            checks++;
            if (inst_class !== e.cls) begin
               errors++;
               $display("FAIL class instr=%h got=%0d exp=%0d", e.instr, inst_class, e.cls);
            end
            checks++;
            if (violation !== e.viol) begin
               errors++;
               $display("FAIL violation instr=%h got=%b exp=%b", e.instr, violation, e.viol);
            end
            checks++;
            if (violation_count !== e.cnt) begin
               errors++;
               $display("FAIL count instr=%h got=%h exp=%h", e.instr, violation_count, e.cnt);
            end
            checks++;
            if (first_bad_instr !== e.first) begin
               errors++;
               $display("FAIL first_bad instr=%h got=%h exp=%h", e.instr, first_bad_instr, e.first);
            end
         end
      end
   end

   initial begin : stimulus
      rst         = 1'b1;
      instr_valid = 1'b0;
      instruction = 32'h0000_0013;
      m_viol  = 1'b0;
      m_cnt   = 16'h0;
      m_first = 32'h0;
      repeat (2) @(posedge clk);

      // Legal vectors
      step(32'h0000_0013, 1, 0, 1, 3'd1);  // nop
      step(32'h0031_00B3, 1, 0, 1, 3'd2);  // add x1,x2,x3
      step(32'h4031_00B3, 1, 0, 1, 3'd2);  // sub
      step(32'hFFF1_0093, 1, 0, 1, 3'd3);  // addi x1,x2,-1
      step(32'h4031_5093, 1, 0, 1, 3'd3);  // srai x1,x2,3
      step(32'h0057_8793, 1, 0, 1, 3'd3);  // addi x15,x15,5
      step(32'h03C0_2283, 1, 0, 1, 3'd4);  // lw x5,60(x0)
      step(32'h0230_2E23, 1, 0, 1, 3'd5);  // sw x3,60(x0)
      step(32'h0231_00B3, 0, 0, MUL_OK, MUL_CLS); // mul, not qualified
      // Illegal while not valid: no state change
      step(32'h0031_08B3, 0, 0, 0, 3'd0);
      // First violation, then a second one that must not overwrite first_bad_instr
      step(32'h0031_08B3, 1, 0, 0, 3'd0);  // add rd=x17
      step(32'h0400_2283, 1, 0, 0, 3'd0);  // lw x5,64(x0)
      step(32'h0030_2123, 1, 0, 0, 3'd0);  // sw x3,2(x0) misaligned
      step(32'h4031_10B3, 1, 0, 0, 3'd0);  // funct7 alt with sll
      step(32'h4031_1093, 1, 0, 0, 3'd0);  // slli with funct7 alt
      step(32'h0010_0013, 1, 0, 0, 3'd0);  // addi x0,x0,1
      step(32'h0101_00B3, 1, 0, 0, 3'd0);  // add rs2=x16
      step(32'h03C0_A283, 1, 0, 0, 3'd0);  // lw base x1
      step(32'hFFC0_2283, 1, 0, 0, 3'd0);  // lw -4(x0)
      step(32'h03C0_0283, 1, 0, 0, 3'd0);  // lb
      step(32'h03C0_2003, 1, 0, 0, 3'd0);  // lw into x0
      step(32'h0080_00EF, 1, 0, 0, 3'd0);  // jal
      step(32'h0000_10B7, 1, 0, 0, 3'd0);  // lui
      step(32'h0000_0073, 1, 0, 0, 3'd0);  // ecall
      step(32'h0231_00B3, 1, 0, MUL_OK, MUL_CLS); // mul qualified
      step(32'h0000_0013, 1, 0, 1, 3'd1);

      // Reset beside a violation: reset wins
      step(32'h0000_0073, 1, 1, 0, 3'd0);
      step(32'h0000_0013, 1, 0, 1, 3'd1);

      // Two illegal words, then a one-cycle reset
      step(32'h0031_08B3, 1, 0, 0, 3'd0);
      step(32'h0400_2283, 1, 0, 0, 3'd0);
      step(32'h0000_0013, 1, 0, 1, 3'd1);  // sees count=2, first=0x003108B3
      step(32'h0000_0013, 0, 1, 1, 3'd1);
      step(32'h0000_0013, 0, 0, 1, 3'd1);  // all registers back to zero

      // Saturation: drive the counter past all-ones
      for (int i = 0; i < 65538; i++)
         step(32'h0000_0073, 1, 0, 0, 3'd0);
      step(32'h0080_00EF, 1, 0, 0, 3'd0);
      step(32'h0000_0013, 0, 0, 1, 3'd1);
      step(32'h0000_0013, 0, 0, 1, 3'd1);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
